// File: rtl/instr_decode_stage_if.sv
// risc_pkg: instruction classes shared by the decode stage and its consumers.
// instr_decode_stage_if: fetch-side valid/ready channel, flush, and the
// decoded-record output channel of instr_decode_stage.
//   master : the surrounding pipeline. It drives in_*, flush and out_ready.
//   slave  : the decode stage. It drives in_ready and out_*.
package risc_pkg;
  typedef enum logic [5:0] {
    RESET, UNKNOWN,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULSU, MULU, DIV, DIVU, REM, REMU,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    LB, LH, LW, LBU, LHU, JALR,
    SB, SH, SW,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LUI, AUIPC, JAL
  } instr_type;
endpackage

interface instr_decode_stage_if;
  import risc_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  instr_type   out_type;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32IM decode stage.
// Accepts one instruction word and its PC per valid/ready handshake and
// classifies the word. It extracts the register indices and the immediate,
// then holds the result in a one-entry output register that supports
// backpressure and flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_decode_stage_if.slave (input channel, flush, output record)
//   ill_cnt    : saturating count of accepted illegal (UNKNOWN) words
module instr_decode_stage
  import risc_pkg::*;
#(
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_decode_stage_if.slave  bus,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  // Operand/immediate layout selected by the decoded class.
  typedef enum logic [2:0] {F_NONE, F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_e;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign ins    = bus.in_instr;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  instr_type   dec_type;
  fmt_e        dec_fmt;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        accept;

  always_comb begin
    dec_type = UNKNOWN;
    dec_fmt  = F_NONE;
    case (opcode)
      7'b0110011: begin
        dec_fmt = F_R;
        case (funct7)
          7'b0000001:
            case (funct3)
              3'd0: dec_type = MUL;
              3'd1: dec_type = MULH;
              3'd2: dec_type = MULSU;
              3'd3: dec_type = MULU;
              3'd4: dec_type = DIV;
              3'd5: dec_type = DIVU;
              3'd6: dec_type = REM;
              3'd7: dec_type = REMU;
            endcase
          7'b0000000:
            case (funct3)
              3'd0: dec_type = ADD;
              3'd1: dec_type = SLL;
              3'd2: dec_type = SLT;
              3'd3: dec_type = SLTU;
              3'd4: dec_type = XOR;
              3'd5: dec_type = SRL;
              3'd6: dec_type = OR;
              3'd7: dec_type = AND;
            endcase
          7'b0100000:
            if (funct3 == 3'd0)      dec_type = SUB;
            else if (funct3 == 3'd5) dec_type = SRA;
          default: ;
        endcase
      end
      7'b0010011: begin
        dec_fmt = F_I;
        case (funct3)
          3'd0: dec_type = ADDI;
          3'd2: dec_type = SLTI;
          3'd3: dec_type = SLTIU;
          3'd4: dec_type = XORI;
          3'd6: dec_type = ORI;
          3'd7: dec_type = ANDI;
          3'd1:
            if (funct7 == 7'b0000000) begin
              dec_type = SLLI;
              dec_fmt  = F_SH;
            end
          3'd5: begin
            dec_fmt = F_SH;
            if (funct7 == 7'b0000000)      dec_type = SRLI;
            else if (funct7 == 7'b0100000) dec_type = SRAI;
          end
        endcase
      end
      7'b0000011: begin
        dec_fmt = F_I;
        case (funct3)
          3'd0:    dec_type = LB;
          3'd1:    dec_type = LH;
          3'd2:    dec_type = LW;
          3'd4:    dec_type = LBU;
          3'd5:    dec_type = LHU;
          default: ;
        endcase
      end
      7'b1100111: begin
        dec_fmt = F_I;
        if (funct3 == 3'd0) dec_type = JALR;
      end
      7'b0100011: begin
        dec_fmt = F_S;
        case (funct3)
          3'd0:    dec_type = SB;
          3'd1:    dec_type = SH;
          3'd2:    dec_type = SW;
          default: ;
        endcase
      end
      7'b1100011: begin
        dec_fmt = F_B;
        case (funct3)
          3'd0:    dec_type = BEQ;
          3'd1:    dec_type = BNE;
          3'd4:    dec_type = BLT;
          3'd5:    dec_type = BGE;
          3'd6:    dec_type = BLTU;
          3'd7:    dec_type = BGEU;
          default: ;
        endcase
      end
      7'b0110111: begin dec_type = LUI;   dec_fmt = F_U; end
      7'b0010111: begin dec_type = AUIPC; dec_fmt = F_U; end
      7'b1101111: begin dec_type = JAL;   dec_fmt = F_J; end
      default: ;
    endcase
    // An unrecognised word carries no operands at all.
    if (dec_type == UNKNOWN) dec_fmt = F_NONE;
  end

  always_comb begin
    dec_rd  = ins[11:7];
    dec_rs1 = ins[19:15];
    dec_rs2 = ins[24:20];
    dec_imm = '0;
    case (dec_fmt)
      F_R: ;
      F_I: begin
        dec_rs2 = '0;
        dec_imm = {{20{ins[31]}}, ins[31:20]};
      end
      F_SH: begin
        dec_rs2 = '0;
        dec_imm = {27'b0, ins[24:20]};
      end
      F_S: begin
        dec_rd  = '0;
        dec_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      F_B: begin
        dec_rd  = '0;
        dec_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      F_U: begin
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_imm = {ins[31:12], 12'b0};
      end
      F_J: begin
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: begin
        dec_rd  = '0;
        dec_rs1 = '0;
        dec_rs2 = '0;
      end
    endcase
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_type    <= RESET;
      bus.out_illegal <= 1'b0;
      bus.out_rd      <= '0;
      bus.out_rs1     <= '0;
      bus.out_rs2     <= '0;
      bus.out_imm     <= '0;
      bus.out_pc      <= '0;
      ill_cnt         <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_type    <= dec_type;
      bus.out_illegal <= (dec_type == UNKNOWN);
      bus.out_rd      <= dec_rd;
      bus.out_rs1     <= dec_rs1;
      bus.out_rs2     <= dec_rs2;
      bus.out_imm     <= dec_imm;
      bus.out_pc      <= bus.in_pc;
      if (dec_type == UNKNOWN && ill_cnt != '1) ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  import risc_pkg::*;

  localparam int FR = 0, FI = 1, FSH = 2, FS = 3, FB = 4, FU = 5, FJ = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_decode_stage_if bus ();
  instr_decode_stage_if bus2 ();
  logic [15:0] ill_cnt;
  logic [1:0]  ill_cnt2;

  instr_decode_stage #(.ILL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ill_cnt(ill_cnt)
  );
  instr_decode_stage #(.ILL_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .ill_cnt(ill_cnt2)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    instr_type   t;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
  } rec_t;

  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
    bit uf3, uf7; instr_type t; int fmt;
  } enc_t;
  enc_t enc[$];

  typedef struct {
    logic [31:0] instr; instr_type t;
    logic [4:0] rd, rs1, rs2; logic [31:0] imm;
  } vec_t;
  vec_t vt[$];

  // ---------------- reference model ----------------
  function automatic void add_enc(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                  bit uf3, bit uf7, instr_type t, int fmt);
    enc_t e;
    e.opc = opc; e.f3 = f3; e.f7 = f7; e.uf3 = uf3; e.uf7 = uf7; e.t = t; e.fmt = fmt;
    enc.push_back(e);
  endfunction

  function automatic void build_enc();
    instr_type mt[8] = '{MUL, MULH, MULSU, MULU, DIV, DIVU, REM, REMU};
    instr_type at[8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    for (int i = 0; i < 8; i++) begin
      add_enc(7'h33, 3'(i), 7'h01, 1, 1, mt[i], FR);
      add_enc(7'h33, 3'(i), 7'h00, 1, 1, at[i], FR);
    end
    add_enc(7'h33, 3'd0, 7'h20, 1, 1, SUB, FR);
    add_enc(7'h33, 3'd5, 7'h20, 1, 1, SRA, FR);
    add_enc(7'h13, 3'd0, 7'h00, 1, 0, ADDI, FI);
    add_enc(7'h13, 3'd2, 7'h00, 1, 0, SLTI, FI);
    add_enc(7'h13, 3'd3, 7'h00, 1, 0, SLTIU, FI);
    add_enc(7'h13, 3'd4, 7'h00, 1, 0, XORI, FI);
    add_enc(7'h13, 3'd6, 7'h00, 1, 0, ORI, FI);
    add_enc(7'h13, 3'd7, 7'h00, 1, 0, ANDI, FI);
    add_enc(7'h13, 3'd1, 7'h00, 1, 1, SLLI, FSH);
    add_enc(7'h13, 3'd5, 7'h00, 1, 1, SRLI, FSH);
    add_enc(7'h13, 3'd5, 7'h20, 1, 1, SRAI, FSH);
    add_enc(7'h03, 3'd0, 7'h00, 1, 0, LB, FI);
    add_enc(7'h03, 3'd1, 7'h00, 1, 0, LH, FI);
    add_enc(7'h03, 3'd2, 7'h00, 1, 0, LW, FI);
    add_enc(7'h03, 3'd4, 7'h00, 1, 0, LBU, FI);
    add_enc(7'h03, 3'd5, 7'h00, 1, 0, LHU, FI);
    add_enc(7'h67, 3'd0, 7'h00, 1, 0, JALR, FI);
    add_enc(7'h23, 3'd0, 7'h00, 1, 0, SB, FS);
    add_enc(7'h23, 3'd1, 7'h00, 1, 0, SH, FS);
    add_enc(7'h23, 3'd2, 7'h00, 1, 0, SW, FS);
    add_enc(7'h63, 3'd0, 7'h00, 1, 0, BEQ, FB);
    add_enc(7'h63, 3'd1, 7'h00, 1, 0, BNE, FB);
    add_enc(7'h63, 3'd4, 7'h00, 1, 0, BLT, FB);
    add_enc(7'h63, 3'd5, 7'h00, 1, 0, BGE, FB);
    add_enc(7'h63, 3'd6, 7'h00, 1, 0, BLTU, FB);
    add_enc(7'h63, 3'd7, 7'h00, 1, 0, BGEU, FB);
    add_enc(7'h37, 3'd0, 7'h00, 0, 0, LUI, FU);
    add_enc(7'h17, 3'd0, 7'h00, 0, 0, AUIPC, FU);
    add_enc(7'h6F, 3'd0, 7'h00, 0, 0, JAL, FJ);
  endfunction

  // Table lookup for the class, plain shift/mask arithmetic for the fields.
  function automatic rec_t ref_decode(logic [31:0] w, logic [31:0] pc);
    rec_t r;
    int fmt = -1;
    logic [31:0] sgn;
    r = '0;
    r.t = UNKNOWN;
    r.pc = pc;
    foreach (enc[k]) begin
      if (fmt < 0 && (w & 32'h7F) == 32'(enc[k].opc) &&
          (!enc[k].uf3 || ((w >> 12) & 32'h7) == 32'(enc[k].f3)) &&
          (!enc[k].uf7 || (w >> 25) == 32'(enc[k].f7))) begin
        fmt = enc[k].fmt;
        r.t = enc[k].t;
      end
    end
    if (fmt < 0) return r;
    sgn = 32'($signed(w) >>> 31);
    r.rd  = 5'((w >> 7) & 32'h1F);
    r.rs1 = 5'((w >> 15) & 32'h1F);
    r.rs2 = 5'((w >> 20) & 32'h1F);
    if (fmt == FS || fmt == FB) r.rd = 0;
    if (fmt == FI || fmt == FSH || fmt == FU || fmt == FJ) r.rs2 = 0;
    if (fmt == FU || fmt == FJ) r.rs1 = 0;
    case (fmt)
      FI:  r.imm = 32'($signed(w) >>> 20);
      FSH: r.imm = (w >> 20) & 32'h1F;
      FS:  r.imm = (32'($signed(w) >>> 25) << 5) | ((w >> 7) & 32'h1F);
      FB:  r.imm = (sgn << 12) | (((w >> 7) & 32'h1) << 11) |
                   (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      FU:  r.imm = w & 32'hFFFFF000;
      FJ:  r.imm = (sgn << 20) | (((w >> 12) & 32'hFF) << 12) |
                   (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      default: r.imm = 0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, enc.size() - 1);
    w = (w & ~32'h7F) | 32'(enc[k].opc);
    if (enc[k].uf3) w = (w & ~(32'h7 << 12)) | (32'(enc[k].f3) << 12);
    if (enc[k].uf7) w = (w & 32'h01FFFFFF) | (32'(enc[k].f7) << 25);
    return w;
  endfunction

  // ---------------- checkers ----------------
  function automatic rec_t dut_rec();
    rec_t r;
    r.t = bus.out_type; r.rd = bus.out_rd; r.rs1 = bus.out_rs1; r.rs2 = bus.out_rs2;
    r.imm = bus.out_imm; r.pc = bus.out_pc;
    return r;
  endfunction

  task automatic check_rec(string name, rec_t exp);
    rec_t a = dut_rec();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got type=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h, want type=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h",
               name, a.t, a.rd, a.rs1, a.rs2, a.imm, a.pc, exp.t, exp.rd, exp.rs1, exp.rs2, exp.imm, exp.pc);
    end
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(logic [31:0] w, instr_type t, logic [4:0] rd,
                                  logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    vec_t v;
    v.instr = w; v.t = t; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    vt.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  rec_t q[$];
  int   m_cnt = 0;

  initial begin
    rec_t exp, held;
    int   accepted_legal, cyc;

    build_enc();
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_instr = '0; bus2.in_pc = '0; bus2.flush = 0; bus2.out_ready = 1;

    // reset state
    #12;
    exp = '0; exp.t = RESET;
    check_rec("reset_rec", exp);
    check_val("reset_valid", 32'(bus.out_valid), 0);
    check_val("reset_illegal", 32'(bus.out_illegal), 0);
    check_val("reset_cnt", 32'(ill_cnt), 0);
    @(negedge clk) rst_n = 1;
    tick();

    // table-driven single-word decode
    add_vec(32'h002081B3, ADD,     3, 1, 2, 32'h0);
    add_vec(32'h027302B3, MUL,     5, 6, 7, 32'h0);
    add_vec(32'hFFF00093, ADDI,    1, 0, 0, 32'hFFFFFFFF);
    add_vec(32'hFE208EE3, BEQ,     0, 1, 2, 32'hFFFFFFFC);
    add_vec(32'h00000000, UNKNOWN, 0, 0, 0, 32'h0);
    add_vec(32'h4000D093, SRAI,    1, 1, 0, 32'h0);
    add_vec(32'hC000D093, UNKNOWN, 0, 0, 0, 32'h0);
    add_vec(32'h123450B7, LUI,     1, 0, 0, 32'h12345000);
    add_vec(32'hFFFFF297, AUIPC,   5, 0, 0, 32'hFFFFF000);
    add_vec(32'h0080006F, JAL,     0, 0, 0, 32'h00000008);
    add_vec(32'h00112423, SW,      0, 2, 1, 32'h00000008);
    add_vec(32'hFFC12083, LW,      1, 2, 0, 32'hFFFFFFFC);
    add_vec(32'h00309093, SLLI,    1, 1, 0, 32'h00000003);
    add_vec(32'h40208133, SUB,     2, 1, 2, 32'h0);
    add_vec(32'h00002063, UNKNOWN, 0, 0, 0, 32'h0);
    add_vec(32'h000080E7, JALR,    1, 1, 0, 32'h0);
    for (int i = 0; i < vt.size(); i++) begin
      bus.in_valid = 1; bus.in_instr = vt[i].instr; bus.in_pc = 32'h100 + 32'(4 * i);
      bus.out_ready = 1;
      tick();
      bus.in_valid = 0;
      if (vt[i].t == UNKNOWN) m_cnt++;
      exp.t = vt[i].t; exp.rd = vt[i].rd; exp.rs1 = vt[i].rs1; exp.rs2 = vt[i].rs2;
      exp.imm = vt[i].imm; exp.pc = 32'h100 + 32'(4 * i);
      check_rec($sformatf("vec%0d_rec", i), exp);
      check_val($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 1);
      check_val($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal), 32'(vt[i].t == UNKNOWN));
      check_val($sformatf("vec%0d_cnt", i), 32'(ill_cnt), 32'(m_cnt));
    end
    tick();
    check_val("idle_valid", 32'(bus.out_valid), 0);

    // backpressure: hold a record for 5 cycles while a new word waits
    bus.in_valid = 1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h200; bus.out_ready = 1;
    tick();
    held = ref_decode(32'h002081B3, 32'h200);
    bus.out_ready = 0; bus.in_instr = 32'h40208133; bus.in_pc = 32'h204;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("stall_in_ready", 32'(bus.in_ready), 0);
      check_val("stall_valid", 32'(bus.out_valid), 1);
      check_rec("stall_hold", held);
      tick();
    end
    bus.out_ready = 1;
    #1;
    check_val("release_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 0;
    check_rec("release_next", ref_decode(32'h40208133, 32'h204));
    check_val("release_valid", 32'(bus.out_valid), 1);
    tick();
    check_val("drain_valid", 32'(bus.out_valid), 0);

    // flush with a pending record and an incoming illegal word
    bus.in_valid = 1; bus.in_instr = 32'hFFC12083; bus.in_pc = 32'h300;
    tick();
    bus.out_ready = 0; bus.in_instr = 32'h00000000; bus.flush = 1;
    #1;
    check_val("flush_in_ready", 32'(bus.in_ready), 0);
    tick();
    bus.flush = 0; bus.in_valid = 0;
    check_val("flush_valid", 32'(bus.out_valid), 0);
    check_val("flush_cnt", 32'(ill_cnt), 32'(m_cnt));
    // flush while idle: in_ready reads high, word still dropped
    bus.out_ready = 1; bus.in_valid = 1; bus.flush = 1;
    #1;
    check_val("flush_idle_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.flush = 0; bus.in_valid = 0;
    check_val("flush_idle_valid", 32'(bus.out_valid), 0);
    check_val("flush_idle_cnt", 32'(ill_cnt), 32'(m_cnt));

    // saturation on the 2-bit counter instance
    bus2.in_valid = 1; bus2.in_instr = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("sat_cnt%0d", i), 32'(ill_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
      check_val($sformatf("sat_illegal%0d", i), 32'(bus2.out_illegal), 1);
    end
    bus2.in_valid = 0;

    // randomized traffic against the scoreboard
    accepted_legal = 0;
    cyc = 0;
    while (accepted_legal < 100 && cyc < 3000) begin
      bit legal, consumed, acc;
      cyc++;
      legal = ($urandom_range(0, 4) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = legal ? rand_legal() : 32'($urandom);
      bus.in_pc     = $urandom & 32'hFFFFFFFC;
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_val("rnd_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check_val("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.out_ready));
      consumed = (q.size() != 0) && bus.out_ready;
      acc = bus.in_valid && (q.size() == 0 || bus.out_ready) && !bus.flush;
      if (consumed) check_rec("rnd_rec", q.pop_front());
      else if (bus.flush && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        exp = ref_decode(bus.in_instr, bus.in_pc);
        q.push_back(exp);
        if (exp.t == UNKNOWN) begin
          if (m_cnt < 65535) m_cnt++;
        end else begin
          accepted_legal++;
        end
      end
      tick();
      check_val("rnd_cnt", 32'(ill_cnt), 32'(m_cnt));
    end
    if (accepted_legal < 100) begin
      errors++;
      $display("FAIL rnd_budget: accepted %0d legal words, want 100", accepted_legal);
    end
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    #1;
    if (q.size() != 0) check_rec("rnd_last", q.pop_front());
    tick();
    check_val("rnd_drained", 32'(bus.out_valid), 0);

    // reset in the middle of a stall
    bus.in_valid = 1; bus.in_instr = 32'h027302B3; bus.in_pc = 32'h400;
    tick();
    bus.out_ready = 0; bus.in_instr = 32'h00000000;
    #3;
    rst_n = 0;
    #1;
    exp = '0; exp.t = RESET;
    check_rec("rst_stall_rec", exp);
    check_val("rst_stall_valid", 32'(bus.out_valid), 0);
    check_val("rst_stall_illegal", 32'(bus.out_illegal), 0);
    check_val("rst_stall_cnt", 32'(ill_cnt), 0);
    tick();
    check_val("rst_no_replay", 32'(bus.out_valid), 0);
    bus.in_valid = 0;
    @(negedge clk) rst_n = 1;
    tick();
    check_val("post_rst_valid", 32'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
